// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall masks,
// FSM state encoding and the zero word.
package pipe_ctrl_pkg;

  localparam logic        AVAIL    = 1'b1;
  localparam logic        UNAVAIL  = 1'b0;
  localparam logic [31:0] ZEROWORD = 32'h0000_0000;

  // Per-source stall masks: bit0 pc .. bit5 wb, 1 = hold.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Deepest requesting stage wins: mem > ex > id.
  function automatic logic [5:0] stall_mask(input logic mem, input logic ex,
                                            input logic id);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// MEM-stall watchdog: counts consecutive stallreq_mem cycles and fires a
// one-cycle pulse on the TIMEOUT-th consecutive stalled cycle.
module pipe_ctrl_stall_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_stall,
  output logic fire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Fire when the stall run reaches TIMEOUT cycles; any gap or a fire restarts it.
  always_comb begin
    fire  = mem_stall && (cnt_q == LIMIT);
    cnt_d = (mem_stall && !fire) ? cnt_q + 16'd1 : 16'd0;
  end

  // Run-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, flush/redirect pulse, deferred
// redirects while a deep stage is stalled, and a MEM-stall watchdog trap.
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_count counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        br_req,
  input  logic [31:0] br_pc,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        wd_fire;
  logic        deep_stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] hold_pc;

  pipe_ctrl_stall_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .mem_stall (stallreq_mem),
    .fire      (wd_fire)
  );

  // Redirect arbitration, deferral into pend_pc and same-cycle outputs.
  always_comb begin
    deep_stall = stallreq_mem | stallreq_ex;
    redir      = exc_req | br_req;
    redir_pc   = exc_req ? exc_pc : br_pc;
    // In HOLD only a fresh exception may replace the deferred target.
    hold_pc    = exc_req ? exc_pc : pend_pc_q;

    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall     = stall_mask(stallreq_mem, stallreq_ex, stallreq_id);
    flush     = 1'b0;
    new_pc    = ZEROWORD;
    timeout   = 1'b0;

    if (wd_fire) begin
      // Bus timeout trap overrides any pending redirect.
      timeout   = 1'b1;
      flush     = 1'b1;
      new_pc    = TRAP_VEC;
      stall     = STALL_NONE;
      pend_pc_d = ZEROWORD;
      state_d   = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_MWAIT: begin
          if (redir && !deep_stall) begin
            // Flush squashes ID, so a concurrent load-use stall is dropped.
            flush   = 1'b1;
            new_pc  = redir_pc;
            stall   = STALL_NONE;
            state_d = ST_RUN;
          end else if (redir) begin
            pend_pc_d = redir_pc;
            state_d   = ST_HOLD;
          end else if (stallreq_mem) begin
            state_d = ST_MWAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HOLD: begin
          if (!deep_stall) begin
            flush     = 1'b1;
            new_pc    = hold_pc;
            stall     = STALL_NONE;
            pend_pc_d = ZEROWORD;
            state_d   = ST_RUN;
          end else begin
            pend_pc_d = hold_pc;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Outputs read as zero for the whole time reset is held.
    if (rst) begin
      stall   = STALL_NONE;
      flush   = 1'b0;
      new_pc  = ZEROWORD;
      timeout = 1'b0;
    end
  end

  // FSM state and deferred redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pend_pc_q <= ZEROWORD;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Free-running wrap-around event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q + ((stall != STALL_NONE) ? 32'd1 : 32'd0);
    flush_count_d  = flush_count_q + (flush ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus computes expected outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] TVC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        br_req = 1'b0, exc_req = 1'b0;
  logic [31:0] br_pc = '0, exc_pc = '0;
  logic [5:0]  stall;
  logic        flush, timeout;
  logic [31:0] new_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_ctrl #(.TIMEOUT(TO), .TRAP_VEC(TVC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_req(br_req), .br_pc(br_pc), .exc_req(exc_req), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .timeout(timeout)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: is a redirect owed, to where, and how long MEM
  // has been stalled without a break.
  bit          pending = 0;
  logic [31:0] pend_addr = '0;
  int          mem_run = 0;
  logic [31:0] n_stall = '0, n_flush = '0;

  task automatic drive(input bit r, input bit m, input bit e, input bit i,
                       input bit b, input logic [31:0] bp,
                       input bit x, input logic [31:0] xp);
    exp_t ex;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst = r; stallreq_mem = m; stallreq_ex = e; stallreq_id = i;
    br_req = b; br_pc = bp; exc_req = x; exc_pc = xp;
    ex.stall = 6'd0; ex.flush = 1'b0; ex.pc = '0; ex.to = 1'b0;
    if (r) begin
      pending = 0; pend_addr = '0; mem_run = 0; n_stall = '0; n_flush = '0;
      ex.sc = '0; ex.fc = '0;
    end else begin
      ex.sc = n_stall; ex.fc = n_flush;
      if (m && mem_run == int'(TO) - 1) begin
        // TIMEOUT-th consecutive MEM stall cycle: trap.
        ex.flush = 1; ex.pc = TVC; ex.to = 1;
        pending = 0; mem_run = 0;
      end else begin
        ex.stall = m ? 6'b011111 : e ? 6'b001111 : i ? 6'b000111 : 6'b000000;
        if (pending || x || b) begin
          if (pending) tgt = x ? xp : pend_addr;
          else         tgt = x ? xp : bp;
          if (!m && !e) begin
            ex.flush = 1; ex.pc = tgt; ex.stall = 6'd0; pending = 0;
          end else begin
            pending = 1; pend_addr = tgt;
          end
        end
        mem_run = m ? mem_run + 1 : 0;
      end
      if (ex.stall != 6'd0) n_stall = n_stall + 1;
      if (ex.flush) n_flush = n_flush + 1;
    end
    exp_q.push_back(ex);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: outputs are combinational, so check mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("timeout", 32'(timeout), 32'(e.to));
      if (e.flush) chk("new_pc", new_pc, e.pc);
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, e.sc);
      chk("flush_count", flush_count, e.fc);
`endif
    end
  end

  initial begin
    // Reset.
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    idle();
    // Load-use stall for one cycle.
    drive(0, 0, 0, 1, 0, '0, 0, '0);
    idle();
    // Unstalled branch.
    drive(0, 0, 0, 0, 1, 32'h80, 0, '0);
    idle();
    // Exception deferred behind a 3-cycle MEM stall.
    drive(0, 1, 0, 0, 0, '0, 1, 32'h200);
    drive(0, 1, 0, 0, 0, '0, 0, '0);
    drive(0, 1, 0, 0, 0, '0, 0, '0);
    idle();
    idle();
    // Watchdog fires on the 4th stalled cycle.
    repeat (4) drive(0, 1, 0, 0, 0, '0, 0, '0);
    idle();
    // Reset while a redirect is held: no flush afterwards.
    drive(0, 1, 0, 0, 1, 32'h300, 0, '0);
    drive(0, 1, 0, 0, 0, '0, 0, '0);
    drive(1, 1, 0, 0, 0, '0, 0, '0);
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    idle();
    idle();
    // HOLD behind EX: exception overwrites, branch ignored.
    drive(0, 0, 1, 0, 1, 32'h400, 0, '0);
    drive(0, 0, 1, 0, 0, '0, 1, 32'h500);
    drive(0, 0, 1, 1, 1, 32'h600, 0, '0);
    drive(0, 0, 0, 1, 0, '0, 0, '0);
    idle();
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15, $urandom,
            $urandom_range(0, 99) < 10, $urandom);
    end
    idle();
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expected 0 queued entries", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
